// File: rtl/sector_busy_ctrl_pkg.sv
// Shared pattern-finder constants for the sector busy controller.
// Sector and key widths match the best-1-of-7 CLCT selector.
package sector_busy_ctrl_pkg;

  localparam int MXCFEB      = 7;
  localparam int MXKEYB      = 5;
  localparam int MXKEYBX     = 8;
  localparam int MXDRIFT     = 4;
  localparam int EDGE_HS     = 2;
  localparam int SECTOR_KEYS = 1 << MXKEYB;

  // A neighbour load may lengthen a holdoff but never shortens one
  function automatic logic [MXDRIFT-1:0] max_drift(input logic [MXDRIFT-1:0] a,
                                                   input logic [MXDRIFT-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sector_busy_ctrl_timer.sv
// Per-sector holdoff down-counter. Busy stays high while the count is nonzero.
// A primary load restarts the count; a neighbour load keeps the longer of the two.
module sector_holdoff_timer
  import sector_busy_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load_pri,
  input  logic               load_nbr,
  input  logic               clear,
  input  logic [MXDRIFT-1:0] drift_delay,
  output logic               busy,
  output logic               busy_nxt
);

  logic [MXDRIFT-1:0] cnt_q, cnt_d;
  logic               busy_q;

  always_comb begin
    cnt_d = (cnt_q != '0) ? cnt_q - MXDRIFT'(1) : '0;
    if (clear) begin
      cnt_d = '0;
    end else if (drift_delay != '0) begin
      if (load_pri)      cnt_d = drift_delay;
      else if (load_nbr) cnt_d = max_drift(cnt_q, drift_delay);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy     = busy_q;
  assign busy_nxt = (cnt_d != '0);

endmodule

// File: rtl/sector_busy_ctrl.sv
// Drives the per-sector busy vector consumed by the CLCT selector. An accepted
// CLCT holds its sector (and optionally a boundary neighbour) busy for drift_delay clocks.
module sector_busy_ctrl
  import sector_busy_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               best_vld,
  input  logic [MXKEYBX-1:0] best_key,
  input  logic               best_bsy,
  input  logic [MXDRIFT-1:0] drift_delay,
  input  logic               edge_en,
  input  logic               resync,
  output logic [MXCFEB-1:0]  bsy,
  output logic               bsy_all,
  output logic               key_err,
  output logic               overlap_err
);

  logic                       acc;
  logic [MXKEYBX-MXKEYB-1:0]  sec;
  logic [MXKEYB-1:0]          key;
  logic                       sec_ok;
  logic                       near_lo;
  logic                       near_hi;
  logic [7:0]                 bsy_pad;
  logic [MXCFEB-1:0]          load_pri;
  logic [MXCFEB-1:0]          load_nbr;
  logic [MXCFEB-1:0]          busy_nxt;
  logic                       bsy_all_q;
  logic                       key_err_q;
  logic                       overlap_err_q;

  assign acc     = best_vld && !best_bsy;
  assign sec     = best_key[MXKEYBX-1:MXKEYB];
  assign key     = best_key[MXKEYB-1:0];
  assign sec_ok  = (sec < 3'(MXCFEB));
  assign near_lo = (key < 5'(EDGE_HS));
  assign near_hi = (key >= 5'(SECTOR_KEYS - EDGE_HS));
  // Pad to 8 so sector 7 indexes a defined, never-busy bit
  assign bsy_pad = {1'b0, bsy};

  for (genvar i = 0; i < MXCFEB; i++) begin : g_sector
    // Sector 7 is excluded by sec_ok, so i+1 / i-1 never reach a missing neighbour
    assign load_pri[i] = acc && sec_ok && (sec == 3'(i));
    assign load_nbr[i] = acc && sec_ok && edge_en &&
                         ((near_lo && (sec == 3'(i + 1))) ||
                          (near_hi && (i > 0) && (sec == 3'(i - 1))));

    sector_holdoff_timer u_timer (
      .clock       (clock),
      .reset_n     (reset_n),
      .load_pri    (load_pri[i]),
      .load_nbr    (load_nbr[i]),
      .clear       (resync),
      .drift_delay (drift_delay),
      .busy        (bsy[i]),
      .busy_nxt    (busy_nxt[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bsy_all_q     <= 1'b0;
      key_err_q     <= 1'b0;
      overlap_err_q <= 1'b0;
    end else begin
      bsy_all_q     <= &busy_nxt;
      key_err_q     <= acc && !resync && !sec_ok;
      overlap_err_q <= acc && !resync && sec_ok && bsy_pad[sec];
    end
  end

  assign bsy_all     = bsy_all_q;
  assign key_err     = key_err_q;
  assign overlap_err = overlap_err_q;

endmodule

// File: tb/tb_sector_busy_ctrl.sv
// Directed bench for sector_busy_ctrl: a cycle model predicts every output
// word into exp_q, which is popped and compared one clock later.
module tb_sector_busy_ctrl;

  logic       clock;
  logic       reset_n;
  logic       best_vld;
  logic [7:0] best_key;
  logic       best_bsy;
  logic [3:0] drift_delay;
  logic       edge_en;
  logic       resync;
  logic [6:0] bsy;
  logic       bsy_all;
  logic       key_err;
  logic       overlap_err;

  int errors = 0;
  int checks = 0;
  int cnt[7];
  logic [9:0] exp_q[$];

  sector_busy_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .best_vld    (best_vld),
    .best_key    (best_key),
    .best_bsy    (best_bsy),
    .drift_delay (drift_delay),
    .edge_en     (edge_en),
    .resync      (resync),
    .bsy         (bsy),
    .bsy_all     (bsy_all),
    .key_err     (key_err),
    .overlap_err (overlap_err)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge, using the currently driven inputs
  task automatic model_push();
    int   nc[7];
    logic [6:0] b_now;
    logic [6:0] b_new;
    logic acc, ke, ov;
    int   s, k, dd;
    acc = best_vld && !best_bsy;
    s   = int'(best_key[7:5]);
    k   = int'(best_key[4:0]);
    dd  = int'(drift_delay);
    ke  = 1'b0;
    ov  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b_now[i] = (cnt[i] != 0);
      nc[i]    = (cnt[i] > 0) ? cnt[i] - 1 : 0;
    end
    if (resync) begin
      for (int i = 0; i < 7; i++) nc[i] = 0;
    end else if (acc) begin
      if (s == 7) begin
        ke = 1'b1;
      end else begin
        ov = b_now[s];
        if (dd != 0) begin
          nc[s] = dd;
          if (edge_en && k < 2 && s > 0)   nc[s-1] = (cnt[s-1] > dd) ? cnt[s-1] : dd;
          if (edge_en && k >= 30 && s < 6) nc[s+1] = (cnt[s+1] > dd) ? cnt[s+1] : dd;
        end
      end
    end
    for (int i = 0; i < 7; i++) begin
      cnt[i]   = nc[i];
      b_new[i] = (nc[i] != 0);
    end
    exp_q.push_back({&b_new, ke, ov, b_new});
  endtask

  task automatic sb_compare();
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("sb_outputs", {22'd0, bsy_all, key_err, overlap_err, bsy}, {22'd0, e});
    end
  endtask

  // Driver: present inputs on a negedge, model the edge, check on the next negedge
  task automatic step(input logic vld, input logic [7:0] key,
                      input logic bb, input logic rs);
    best_vld = vld;
    best_key = key;
    best_bsy = bb;
    resync   = rs;
    model_push();
    @(posedge clock);
    @(negedge clock);
    sb_compare();
    best_vld = 1'b0;
    best_bsy = 1'b0;
    resync   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n     = 1'b0;
    best_vld    = 1'b0;
    best_key    = 8'h00;
    best_bsy    = 1'b0;
    drift_delay = 4'd4;
    edge_en     = 1'b0;
    resync      = 1'b0;
    for (int i = 0; i < 7; i++) cnt[i] = 0;

    repeat (2) @(negedge clock);
    chk("reset_outputs", {28'd0, bsy_all, key_err, overlap_err, |bsy}, 32'd0);
    reset_n = 1'b1;

    // Single accept, sector 2 k=5, drift 4
    idle(9);
    step(1'b1, 8'h45, 1'b0, 1'b0);
    chk("s2_first_cycle", {25'd0, bsy}, 32'h04);
    idle(3);
    chk("s2_last_cycle", {25'd0, bsy}, 32'h04);
    idle(1);
    chk("s2_released", {25'd0, bsy}, 32'h00);

    // Boundary neighbours
    edge_en = 1'b1;
    drift_delay = 4'd3;
    step(1'b1, 8'h60, 1'b0, 1'b0);
    chk("nbr_lo_s3_s2", {25'd0, bsy}, 32'h0C);
    idle(3);
    step(1'b1, 8'hDF, 1'b0, 1'b0);
    chk("s6_no_upper_nbr", {25'd0, bsy}, 32'h40);
    idle(3);
    step(1'b1, 8'h1F, 1'b0, 1'b0);
    chk("nbr_hi_s0_s1", {25'd0, bsy}, 32'h03);
    idle(3);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    chk("s0_no_lower_nbr", {25'd0, bsy}, 32'h01);
    idle(3);
    // Neighbour lengthens a shorter running holdoff
    drift_delay = 4'd2;
    step(1'b1, 8'h85, 1'b0, 1'b0);
    drift_delay = 4'd6;
    step(1'b1, 8'h7F, 1'b0, 1'b0);
    idle(7);

    // Re-accept while busy
    edge_en = 1'b0;
    drift_delay = 4'd6;
    step(1'b1, 8'h25, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 8'h25, 1'b0, 1'b0);
    chk("overlap_pulse", {31'd0, overlap_err}, 32'd1);
    idle(5);
    chk("reaccept_hold", {25'd0, bsy}, 32'h02);
    idle(1);
    chk("reaccept_end", {25'd0, bsy}, 32'h00);

    // Bad sector and selector-busy accepts
    step(1'b1, 8'hE3, 1'b0, 1'b0);
    chk("key_err_pulse", {31'd0, key_err}, 32'd1);
    idle(1);
    step(1'b1, 8'h45, 1'b1, 1'b0);
    idle(1);

    // Fill every sector, then resync over a simultaneous accept
    drift_delay = 4'd15;
    for (int s = 0; s < 7; s++) step(1'b1, {3'(s), 5'd5}, 1'b0, 1'b0);
    chk("bsy_all_set", {31'd0, bsy_all}, 32'd1);
    idle(2);
    step(1'b1, 8'h45, 1'b0, 1'b1);
    chk("resync_clear", {24'd0, overlap_err, bsy}, 32'd0);
    idle(2);

    // Reset in the middle of a holdoff
    drift_delay = 4'd5;
    step(1'b1, 8'h85, 1'b0, 1'b0);
    idle(1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_clear", {25'd0, bsy}, 32'd0);
    for (int i = 0; i < 7; i++) cnt[i] = 0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);

    // Zero drift disables busy
    drift_delay = 4'd0;
    step(1'b1, 8'h45, 1'b0, 1'b0);
    chk("drift0_no_busy", {25'd0, bsy}, 32'd0);
    idle(2);

    // Random accepts against the model
    edge_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drift_delay = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
    end

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
